// File: rtl/uart_cmd_pkg.sv
// Shared types and frame constants for the UART command slave.
package uart_cmd_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    WAIT_HI,
    WAIT_LO
  } asm_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_XMIT
  } tx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: RX double-flop synchroniser, mid-bit sampling FSM, byte/framing-error pulses.
module uart_rx_core
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 109
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_byte,
  output logic       byte_rdy,
  output logic       frm_err
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  logic             sync1_q, sync2_q, prev_q;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_rdy_q, byte_rdy_d;
  logic             frm_err_q, frm_err_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_rdy_d = 1'b0;
    frm_err_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'(DATA_BITS - 1)) state_d = RX_STOP;
          else                            bit_d   = bit_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) byte_rdy_d = 1'b1;
          else         frm_err_d  = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_rdy_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      sync1_q    <= RX;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_rdy_q <= byte_rdy_d;
      frm_err_q  <= frm_err_d;
    end
  end

  assign rx_byte  = shift_q;
  assign byte_rdy = byte_rdy_q;
  assign frm_err  = frm_err_q;

endmodule

// File: rtl/uart_cmd_slave.sv
// Host command link slave: assembles two received bytes into a 16-bit command, sends response bytes.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_slave
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV       = 109,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frm_err
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);

  logic [7:0] rx_byte;
  logic       byte_rdy;

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .rx_byte  (rx_byte),
    .byte_rdy (byte_rdy),
    .frm_err  (frm_err)
  );

  asm_state_t  asm_q, asm_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    asm_d     = asm_q;
    hi_d      = hi_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = clr_cmd_rdy ? 1'b0 : cmd_rdy_q;
`ifdef CMD_TIMEOUT_EN
    to_cnt_d  = (asm_q == WAIT_LO) ? to_cnt_q + 1'b1 : '0;
`endif
    case (asm_q)
      WAIT_HI: begin
        if (byte_rdy) begin
          hi_d      = rx_byte;
          cmd_rdy_d = 1'b0;
          asm_d     = WAIT_LO;
        end
      end
      WAIT_LO: begin
        // Completion overrides a simultaneous clear.
        if (byte_rdy) begin
          cmd_d     = {hi_q, rx_byte};
          cmd_rdy_d = 1'b1;
          asm_d     = WAIT_HI;
        end else if (frm_err) begin
          hi_d  = '0;
          asm_d = WAIT_HI;
        end
`ifdef CMD_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          hi_d  = '0;
          asm_d = WAIT_HI;
        end
`endif
      end
      default: asm_d = WAIT_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q     <= WAIT_HI;
      hi_q      <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      hi_q      <= hi_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

`ifdef CMD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`endif

  tx_state_t        tx_state_q, tx_state_d;
  logic [9:0]       tx_shift_q, tx_shift_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic             tx_q, tx_d;
  logic             tx_busy_q, tx_busy_d;
  logic             resp_sent_q, resp_sent_d;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_shift_d  = tx_shift_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_q_hold: begin end
    tx_d        = tx_q;
    tx_busy_d   = tx_busy_q;
    resp_sent_d = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (send_resp) begin
          tx_shift_d = {1'b1, resp, 1'b0};
          tx_d       = 1'b0;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_busy_d  = 1'b1;
          tx_state_d = TX_XMIT;
        end
      end
      TX_XMIT: begin
        // TX is registered: the next bit is taken from shift[1] as the current one expires.
        if (tx_cnt_q == FULL_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'(FRAME_BITS - 1)) begin
            tx_d        = 1'b1;
            tx_busy_d   = 1'b0;
            resp_sent_d = 1'b1;
            tx_state_d  = TX_IDLE;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_shift_q  <= '1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_q        <= 1'b1;
      tx_busy_q   <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_shift_q  <= tx_shift_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_q        <= tx_d;
      tx_busy_q   <= tx_busy_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign TX        = tx_q;
  assign tx_busy   = tx_busy_q;
  assign resp_sent = resp_sent_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Directed self-checking bench for uart_cmd_slave at BAUD_DIV=109.
module tb_uart_cmd_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        tx_busy;
  logic        frm_err;

  int checks = 0;
  int errors = 0;
  int frm_cnt = 0;
  int rise_n = 0;

  uart_cmd_slave #(.BAUD_DIV(109), .TIMEOUT_CYCLES(5000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .tx_busy     (tx_busy),
    .frm_err     (frm_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frm_err) frm_cnt <= frm_cnt + 1;

  // Drives one 8N1 frame starting on a falling clock edge; rise_n records the cycle cmd_rdy rose.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int clr_at);
    logic [9:0] fr;
    logic       prev;
    fr = {stop_bit, b, 1'b0};
    @(negedge clk);
    RX = 1'b0;
    prev = cmd_rdy;
    rise_n = 0;
    for (int n = 1; n <= 1090; n++) begin
      @(negedge clk);
      if (cmd_rdy && !prev && rise_n == 0) rise_n = n;
      prev = cmd_rdy;
      clr_cmd_rdy = (n == clr_at);
      if (n % 109 == 0 && n < 1090) RX = fr[n / 109];
    end
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic idle(input int cycles);
    RX = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (TX !== 1'b1)      begin errors++; $display("FAIL reset_tx got %b exp 1", TX); end
    checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL reset_cmd got %h exp 0000", cmd); end
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_cmd_rdy got %b exp 0", cmd_rdy); end
    checks++; if (resp_sent !== 1'b0) begin errors++; $display("FAIL reset_resp_sent got %b exp 0", resp_sent); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy got %b exp 0", tx_busy); end
    checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL reset_frm_err got %b exp 0", frm_err); end
    rst_n = 1'b1;
    idle(10);
  endtask

  task automatic test_cmd;
    send_byte(8'h0A, 1'b1, 0);
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL cmd_hi_only_rdy got %b exp 0", cmd_rdy); end
    send_byte(8'hBC, 1'b1, 0);
    checks++; if (rise_n !== 1039) begin errors++; $display("FAIL cmd_latency got %0d exp 1039", rise_n); end
    checks++; if (cmd !== 16'h0ABC) begin errors++; $display("FAIL cmd_0abc got %h exp 0abc", cmd); end
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL clr_rdy got %b exp 0", cmd_rdy); end
    checks++; if (cmd !== 16'h0ABC) begin errors++; $display("FAIL clr_cmd_stable got %h exp 0abc", cmd); end
  endtask

  task automatic test_glitch;
    int f0;
    f0 = frm_cnt;
    @(negedge clk);
    RX = 1'b0;
    repeat (30) @(negedge clk);
    idle(300);
    checks++; if (frm_cnt !== f0) begin errors++; $display("FAIL glitch_frm got %0d exp %0d", frm_cnt, f0); end
    send_byte(8'h12, 1'b1, 0);
    send_byte(8'h34, 1'b1, 0);
    checks++; if (cmd !== 16'h1234) begin errors++; $display("FAIL glitch_cmd got %h exp 1234", cmd); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL glitch_rdy got %b exp 1", cmd_rdy); end
  endtask

  task automatic test_frm_err;
    int f0;
    f0 = frm_cnt;
    send_byte(8'h55, 1'b0, 0);
    idle(200);
    checks++; if (frm_cnt !== f0 + 1) begin errors++; $display("FAIL frm_pulse got %0d exp %0d", frm_cnt, f0 + 1); end
    send_byte(8'h66, 1'b1, 0);
    send_byte(8'h77, 1'b1, 0);
    checks++; if (cmd !== 16'h6677) begin errors++; $display("FAIL frm_cmd got %h exp 6677", cmd); end
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b0, 0);
    idle(200);
    send_byte(8'h33, 1'b1, 0);
    send_byte(8'h44, 1'b1, 0);
    checks++; if (cmd !== 16'h3344) begin errors++; $display("FAIL frm_lo_drop got %h exp 3344", cmd); end
    checks++; if (frm_cnt !== f0 + 2) begin errors++; $display("FAIL frm_pulse2 got %0d exp %0d", frm_cnt, f0 + 2); end
  endtask

  task automatic test_tx;
    logic [9:0] exp_fr;
    int         rs_n;
    int         rs_cnt;
    exp_fr = 10'b1_1010_0101_0;
    rs_n = 0;
    rs_cnt = 0;
    @(negedge clk);
    resp = 8'hA5;
    send_resp = 1'b1;
    for (int n = 1; n <= 1100; n++) begin
      @(negedge clk);
      send_resp = (n == 300);
      resp = (n == 300) ? 8'hFF : 8'h00;
      if ((n - 1) % 109 == 54 && (n - 1) / 109 < 10) begin
        checks++;
        if (TX !== exp_fr[(n - 1) / 109]) begin
          errors++; $display("FAIL tx_bit%0d got %b exp %b", (n - 1) / 109, TX, exp_fr[(n - 1) / 109]);
        end
      end
      if (n == 500) begin
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_mid got %b exp 1", tx_busy); end
      end
      if (resp_sent) begin
        rs_cnt++;
        if (rs_n == 0) rs_n = n;
      end
    end
    checks++; if (rs_n !== 1091) begin errors++; $display("FAIL resp_sent_time got %0d exp 1091", rs_n); end
    checks++; if (rs_cnt !== 1) begin errors++; $display("FAIL resp_sent_width got %0d exp 1", rs_cnt); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL tx_busy_end got %b exp 0", tx_busy); end
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL tx_idle got %b exp 1", TX); end
  endtask

  task automatic test_set_wins;
    send_byte(8'hDE, 1'b1, 0);
    send_byte(8'hAD, 1'b1, 1038);
    checks++; if (rise_n !== 1039) begin errors++; $display("FAIL set_wins_rise got %0d exp 1039", rise_n); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL set_wins_rdy got %b exp 1", cmd_rdy); end
    checks++; if (cmd !== 16'hDEAD) begin errors++; $display("FAIL set_wins_cmd got %h exp dead", cmd); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    resp = 8'h00;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    RX = 1'b0;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (TX !== 1'b1)      begin errors++; $display("FAIL rst_mid_tx got %b exp 1", TX); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", tx_busy); end
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL rst_mid_rdy got %b exp 0", cmd_rdy); end
    checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL rst_mid_cmd got %h exp 0000", cmd); end
    repeat (5) @(negedge clk);
    RX = 1'b1;
    rst_n = 1'b1;
    idle(20);
    send_byte(8'h0F, 1'b1, 0);
    send_byte(8'hF0, 1'b1, 0);
    checks++; if (cmd !== 16'h0FF0) begin errors++; $display("FAIL rst_mid_next_cmd got %h exp 0ff0", cmd); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_next_rdy got %b exp 1", cmd_rdy); end
  endtask

  task automatic test_timeout;
    send_byte(8'hAA, 1'b1, 0);
    idle(6000);
    send_byte(8'h01, 1'b1, 0);
`ifdef CMD_TIMEOUT_EN
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL to_first_rdy got %b exp 0", cmd_rdy); end
    send_byte(8'h02, 1'b1, 0);
    checks++; if (cmd !== 16'h0102) begin errors++; $display("FAIL to_cmd got %h exp 0102", cmd); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL to_rdy got %b exp 1", cmd_rdy); end
`else
    checks++; if (cmd !== 16'hAA01) begin errors++; $display("FAIL wait_lo_cmd got %h exp aa01", cmd); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL wait_lo_rdy got %b exp 1", cmd_rdy); end
    send_byte(8'h02, 1'b1, 0);
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL wait_lo_hi_clr got %b exp 0", cmd_rdy); end
`endif
  endtask

  initial begin
    test_reset;
    test_cmd;
    test_glitch;
    test_frm_err;
    test_tx;
    test_set_wins;
    test_reset_mid;
    test_timeout;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_slave.md
Name: uart_cmd_slave

Overview:
- DUT-side end of the host command link. Receives 16-bit commands as two 8N1 UART bytes, high byte first, and presents each as a parallel word with a ready flag. Serialises single response bytes back to the host.
- Sits in the digital core between the RX/TX pins and the command dispatcher. It is the counterpart of the host-side command master.

Parameters:
- BAUD_DIV, 109: clk cycles per bit (100 MHz clk, ~921600 baud); minimum 8.
- TIMEOUT_CYCLES, 65536: inter-byte timeout in clk cycles; used only with CMD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset.
- RX  in  1  serial input from host, idle high, asynchronous to clk.
- TX  out  1  serial output to host, idle high.
- cmd  out  16  last complete command, {high byte, low byte}.
- cmd_rdy  out  1  set when a complete command has been assembled.
- clr_cmd_rdy  in  1  one-cycle pulse; clears cmd_rdy.
- resp  in  8  response byte to transmit.
- send_resp  in  1  one-cycle pulse; starts transmission of resp.
- resp_sent  out  1  one-cycle pulse when the response stop bit completes.
- tx_busy  out  1  high while a response frame is in flight.
- frm_err  out  1  one-cycle pulse when a received stop bit samples low.

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-low (rst_n).
- Reset values: TX=1, cmd=0, cmd_rdy=0, resp_sent=0, tx_busy=0, frm_err=0. The RX synchroniser flops are preset to 1.
- RX synchronisation: double-flopped. All receive decisions use the second flop.
- Receiver FSM, states IDLE, START, DATA, STOP:
  - IDLE -> START on a synchronised falling edge.
  - START waits BAUD_DIV/2 (floor) cycles, then samples. A sample of 1 is a glitch: return to IDLE with no pulse. A sample of 0 goes to DATA.
  - DATA samples 8 bits LSB first, each BAUD_DIV cycles after the previous sample.
  - STOP samples after BAUD_DIV cycles. Sample 1 produces an internal byte_rdy pulse. Sample 0 pulses frm_err and discards the byte.
  - Every exit from STOP returns to IDLE. A new falling edge is accepted on the cycle after STOP.
- Assembler FSM, states WAIT_HI, WAIT_LO:
  - byte_rdy in WAIT_HI: latch the high byte and clear cmd_rdy. Go to WAIT_LO.
  - byte_rdy in WAIT_LO: cmd <= {hi, byte} and cmd_rdy <= 1 on the same edge. Go to WAIT_HI.
  - A framing error in WAIT_LO returns to WAIT_HI and drops the latched high byte.
- cmd_rdy rules:
  - If the set and clr_cmd_rdy occur in the same cycle, the set wins.
  - A command completing while cmd_rdy=1 overwrites cmd; cmd_rdy stays 1.
  - cmd is stable between completions.
- Receive latency: cmd_rdy rises 1 cycle after the low-byte stop-bit sample.
- Transmitter FSM, states IDLE, XMIT:
  - send_resp in IDLE loads the shift register with {1, resp, 0} and sets tx_busy. TX drives the start bit on the next edge.
  - Each bit is held BAUD_DIV cycles. After 10 bits: TX=1, tx_busy=0, and resp_sent pulses on the same edge.
  - send_resp while tx_busy is ignored. resp is sampled only on the accepting cycle.
- Transmit and receive are fully independent; full-duplex operation is legal.
- Reset mid-frame: both FSMs return to idle immediately. A partial byte is lost and TX returns high asynchronously.

Optional Feature:
- CMD_TIMEOUT_EN defined:
  - A counter runs in WAIT_LO. Reaching TIMEOUT_CYCLES without a byte_rdy returns the assembler to WAIT_HI and discards the high byte.
  - The counter restarts on every byte_rdy.
- CMD_TIMEOUT_EN undefined: no counter is present. WAIT_LO waits indefinitely. TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - the rx_state_t, asm_state_t and tx_state_t enums;
  - the frame constants DATA_BITS=8 and FRAME_BITS=10.
- One sub-module, uart_rx_core: synchroniser, receiver FSM, baud counter. Outputs rx_byte[7:0], byte_rdy and frm_err.
- Assembler and transmitter live in the top module.

Test Plan:
- Drive 0x0A then 0xBC at BAUD_DIV=109 -> cmd=16'h0ABC, cmd_rdy rises 1 cycle after the second stop-bit sample. clr_cmd_rdy pulse -> cmd_rdy=0, cmd unchanged.
- RX low pulse of 30 cycles, then idle -> no byte_rdy, no frm_err. A following valid 0x12, 0x34 -> cmd=16'h1234.
- Byte 0x55 with stop bit forced 0, then 0x66, 0x77 -> frm_err pulses once, cmd=16'h6677.
- send_resp with resp=8'hA5 -> TX bits 0,1,0,1,0,0,1,0,1,1, each held 109 cycles. resp_sent pulses 1090 cycles after accept. A second send_resp mid-frame is ignored.
- clr_cmd_rdy asserted in the cycle cmd_rdy sets -> cmd_rdy=1. Assert rst_n low mid-DATA -> TX=1, cmd_rdy=0, and the next full command is received correctly.
- CMD_TIMEOUT_EN with TIMEOUT_CYCLES=5000: send 0xAA, wait 6000 cycles, send 0x01, 0x02 -> cmd=16'h0102, never 0xAA01.
